// File: rtl/mul_div_unit_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        done;
  logic [63:0] result;

  modport master (
    output start, op, flush, src_a, src_b,
    input  stall, done, result
  );

  modport slave (
    input  start, op, flush, src_a, src_b,
    output stall, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for EX; stalls the pipeline
// and emits {hi, lo} with a one-cycle write strobe for HI/LO.
module mul_div_unit #(
  parameter int DIV_ITERS = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   a_q, b_q, dq_q;
  logic [32:0]   rem_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q, sign_r;
  logic          done_q;
  logic [63:0]   result_q;

  logic        sgn, is_div, b_zero;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, rem_n;
  logic        ge;
  logic [31:0] dq_n, quo_f, rem_f;
  logic [63:0] prod, prod_f;

  always_comb begin
    sgn    = ~bus.op[0];
    is_div = bus.op[1];
    b_zero = bus.src_b == 32'h0;
    a_abs  = (sgn & bus.src_a[31]) ? -bus.src_a
                                   : bus.src_a;
    b_abs  = (sgn & bus.src_b[31]) ? -bus.src_b
                                   : bus.src_b;
  end

  // one restoring-division step, quotient bits shift in at the bottom
  always_comb begin
    rem_sh = {rem_q[31:0], dq_q[31]};
    ge     = rem_sh >= {1'b0, b_q};
    rem_n  = ge ? rem_sh - {1'b0, b_q} : rem_sh;
    dq_n   = {dq_q[30:0], ge};
    quo_f  = sign_q ? -dq_n : dq_n;
    rem_f  = sign_r ? -rem_n[31:0] : rem_n[31:0];
    prod   = 64'(a_q) * 64'(b_q);
    prod_f = sign_q ? -prod : prod;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (!is_div)     state_d = MUL;
            else if (b_zero) state_d = DONE;
            else             state_d = DIV;
          end
        end
        MUL:  state_d = DONE;
        DIV:  if (cnt_q == LAST) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stall  = 1'b0;
    bus.done   = done_q;
    bus.result = result_q;
    unique case (state_q)
      IDLE:    bus.stall = bus.start & ~bus.flush;
      MUL:     bus.stall = ~bus.flush;
      DIV:     bus.stall = ~bus.flush;
      default: bus.stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      done_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q    <= a_abs;
            b_q    <= b_abs;
            dq_q   <= a_abs;
            rem_q  <= '0;
            cnt_q  <= '0;
            sign_q <= sgn & (bus.src_a[31] ^ bus.src_b[31]);
            sign_r <= sgn & bus.src_a[31];
            // divide by zero skips straight to the write-back
            if (is_div && b_zero) begin
              done_q   <= 1'b1;
              result_q <= {bus.src_a, 32'hFFFF_FFFF};
            end
          end
        end
        MUL: begin
          done_q   <= 1'b1;
          result_q <= prod_f;
        end
        DIV: begin
          rem_q <= rem_n;
          dq_q  <= dq_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            done_q   <= 1'b1;
            result_q <= {rem_f, quo_f};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus
// flush, reset, back-to-back and start/flush corner sequences.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  mul_div_unit_if bus ();

  mul_div_unit #(.DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int got;
    got = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.src_a = v.a;
    bus.src_b = v.b;
    #1;
    chk({v.name, " stall c0"}, 64'(bus.stall), 64'd1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.done === 1'b1) begin
        got = c;
        break;
      end
      chk({v.name, " stall busy"}, 64'(bus.stall), 64'd1);
    end
    chk({v.name, " latency"}, 64'(got), 64'(v.lat));
    if (got >= 0) begin
      chk({v.name, " result"}, bus.result, v.exp);
      chk({v.name, " stall done"}, 64'(bus.stall), 64'd0);
      @(negedge clk);
      #1;
      chk({v.name, " done pulse"}, 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int ndone;
    int got;

    vecs[0] = '{"mult", 2'b00, 32'hFFFF_FFFE, 32'h3,
                64'hFFFF_FFFF_FFFF_FFFA, 2};
    vecs[1] = '{"multu", 2'b01, 32'hFFFF_FFFE, 32'h3,
                64'h0000_0002_FFFF_FFFA, 2};
    vecs[2] = '{"mult_negneg", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFB,
                64'd25, 2};
    vecs[3] = '{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, 2};
    vecs[4] = '{"div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h2,
                64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[5] = '{"divu_100_7", 2'b11, 32'd100, 32'd7,
                {32'd2, 32'd14}, 33};
    vecs[6] = '{"div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h0, 32'h8000_0000}, 33};
    vecs[7] = '{"divu_by0", 2'b11, 32'd5, 32'd0,
                {32'd5, 32'hFFFF_FFFF}, 1};
    vecs[8] = '{"div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0,
                {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 1};
    vecs[9] = '{"div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE,
                {32'd1, 32'hFFFF_FFFD}, 33};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.flush = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // flush a DIVU in cycle 10, then MULTU 3x4 in cycle 11
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 10) bus.flush = 1'b1;
      #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("flush stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    #1;
    if (bus.done === 1'b1) ndone++;
    chk("flush no done", 64'(ndone), 64'd0);
    chk("flush restart stall", 64'(bus.stall), 64'd1);
    got = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.done === 1'b1) begin
        got = c;
        break;
      end
    end
    chk("after flush latency", 64'(got), 64'd2);
    chk("after flush result", bus.result, 64'd12);

    // reset in cycle 5 of a DIV
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst mid done", 64'(bus.done), 64'd0);
    chk("rst mid stall", 64'(bus.stall), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1 || bus.stall === 1'b1) ndone++;
    end
    chk("rst mid no activity", 64'(ndone), 64'd0);

    // start held high through DONE, then a new op in IDLE
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.src_a = 32'hFFFF_FFFE;
    bus.src_b = 32'd3;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("b2b done cycle2", 64'(bus.done), 64'd1);
    chk("b2b stall in done", 64'(bus.stall), 64'd0);
    chk("b2b mult result", bus.result,
        64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    bus.op    = 2'b01;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    #1;
    if (bus.done === 1'b1) ndone++;
    chk("b2b one pulse", 64'(ndone), 64'd1);
    chk("b2b restart stall", 64'(bus.stall), 64'd1);
    got = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.done === 1'b1) begin
        got = c;
        break;
      end
    end
    chk("b2b second latency", 64'(got), 64'd2);
    chk("b2b second result", bus.result, 64'd12);

    // start and flush together in IDLE
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b11;
    bus.src_a = 32'd9;
    bus.src_b = 32'd0;
    #1;
    chk("start+flush stall", 64'(bus.stall), 64'd0);
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.done === 1'b1 || bus.stall === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("start+flush idle", 64'(ndone), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the MIPS pipeline.
- Executes MULT, MULTU, DIV and DIVU, and stalls the pipeline while it works.
- Produces the 64-bit {hi, lo} value and a one-cycle write strobe.
- Those two outputs drive the HI/LO register's hilo_in and we inputs directly.

Parameters:
- DIV_ITERS, 32, number of radix-2 restoring-division iterations; fixed at the operand width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  EX holds a mul/div instruction; sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- flush  input  1  EX flush (exception/eret); aborts any operation in flight
- src_a  input  32  rs operand (multiplicand / dividend); sampled with start
- src_b  input  32  rt operand (multiplier / divisor); sampled with start
- stall  output  1  combinational; holds the pipeline while the result is pending
- done  output  1  registered; one-cycle pulse; used as the HI/LO write enable
- result  output  64  {hi, lo}; valid only while done=1

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset and flush both force IDLE, done=0, result=0, counter=0.
- stall = (state==IDLE & start & ~flush) | state==MUL | state==DIV. stall is 0 in DONE, so the pipeline advances on that cycle.
- Cycle numbering: the cycle start is accepted in IDLE is cycle 0.
- Operand capture:
  - Capture op and src_a/src_b in cycle 0.
  - Signed ops convert operands to magnitudes and record sign_q = a[31]^b[31] and sign_r = a[31].
- Multiply:
  - IDLE->MUL. Cycle 1: registered 32x32 magnitude product. MUL->DONE.
  - Cycle 2: done=1 and result = product, negated as two's complement when signed and sign_q=1.
  - Multiply latency is therefore 2.
- Divide:
  - IDLE->DIV. 32 iterations over cycles 1..32, one quotient bit per cycle, MSB first.
  - Each iteration: shift the 33-bit partial remainder left, compare against the divisor, subtract if >=.
  - After iteration 32: DIV->DONE. Cycle 33: done=1. Divide latency is therefore 33.
  - Sign fix-up in the DONE cycle: negate the quotient if sign_q=1; negate the remainder if sign_r=1.
  - result = {remainder, quotient}, i.e. hi=remainder, lo=quotient.
- Divide by zero (src_b==0):
  - Detected in cycle 0; IDLE->DONE directly, done=1 in cycle 1.
  - result = {src_a, 32'hFFFF_FFFF}, for both DIV and DIVU.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives result = {32'h0, 32'h80000000}, with normal latency.
- DONE always returns to IDLE next cycle. A start seen during DONE is ignored; the issuing instruction leaves EX that cycle.
- flush has priority over every state transition; it is asserted mid-operation:
  - No done pulse is produced.
  - Next cycle is IDLE.
  - stall deasserts in the same cycle as flush.
- Simultaneous start and flush in IDLE: nothing is captured and stall=0.
- rst overrides flush and start.
- result holds its last value outside DONE. Consumers must qualify it with done.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003 -> stall high in cycles 0-1; cycle 2 done=1, result=0xFFFFFFFF_FFFFFFFA. MULTU on the same operands -> result=0x00000002_FFFFFFFA.
- DIV -7 / 2 -> stall for cycles 0-32; cycle 33 done=1, result={0xFFFFFFFF, 0xFFFFFFFD}. DIVU 100 / 7 -> result={2, 14}.
- DIV 0x80000000 / 0xFFFFFFFF -> result={0x0, 0x80000000}. DIVU 5 / 0 -> cycle 1 done=1, result={0x5, 0xFFFFFFFF}.
- Start DIVU, assert flush in cycle 10 -> stall=0 in cycle 10; no done pulse; state IDLE in cycle 11. A new MULTU 3×4 accepted in cycle 11 -> done in cycle 13, result=12.
- Assert rst in cycle 5 of a DIV -> done=0 and stall=0 from cycle 6; no result is written.
- Back-to-back: MULT, then start held high through DONE -> exactly one done pulse. The next start in the IDLE cycle after DONE is accepted as a new operation.
